// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter_if
// Brief    : Requester, response and shared-ALU signals of the ALU arbiter.
// Revision : 1.0
// ============================================================================
interface alu_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
);
    localparam int c_gw = ($clog2(NREQ) > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ*3-1:0]     req_op;
    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ-1:0]       rsp_ready;
    logic [WIDTH-1:0]      rsp_y;
    logic [3:0]            rsp_flags;
    logic [WIDTH-1:0]      alu_a;
    logic [WIDTH-1:0]      alu_b;
    logic [2:0]            alu_op;
    logic [WIDTH-1:0]      alu_y;
    logic                  alu_overflow;
    logic                  alu_carry;
    logic                  alu_zero;
    logic                  alu_negative;
    logic                  busy;
    logic [c_gw-1:0]       grant_id;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
               alu_y, alu_overflow, alu_carry, alu_zero, alu_negative,
        input  req_ready, rsp_valid, rsp_y, rsp_flags,
               alu_a, alu_b, alu_op, busy, grant_id
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
               alu_y, alu_overflow, alu_carry, alu_zero, alu_negative,
        output req_ready, rsp_valid, rsp_y, rsp_flags,
               alu_a, alu_b, alu_op, busy, grant_id
    );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Brief    : Round-robin arbiter sharing one combinational ALU between NREQ
//            requesters; one operation in flight, result held until taken.
// Revision : 1.0
// ============================================================================
module alu_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    alu_arbiter_if.slave     bus
);
    localparam int c_gw = ($clog2(NREQ) > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] c_one       = NREQ'(1);
    localparam logic [c_gw-1:0] c_last_init = c_gw'(NREQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [c_gw-1:0]  last_grant_q, last_grant_d;
    logic [c_gw-1:0]  grant_q, grant_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [3:0]       flags_q, flags_d;

    logic [WIDTH-1:0] w_a  [NREQ];
    logic [WIDTH-1:0] w_b  [NREQ];
    logic [2:0]       w_op [NREQ];
    logic             w_found;
    logic [c_gw-1:0]  w_win;

    generate
        for (genvar g = 0; g < NREQ; g++) begin : g_unpack
            assign w_a[g]  = bus.req_a[g*WIDTH +: WIDTH];
            assign w_b[g]  = bus.req_b[g*WIDTH +: WIDTH];
            assign w_op[g] = bus.req_op[g*3 +: 3];
        end
    endgenerate

    // First pending requester at or after the one following the last grant.
    always_comb begin : p_arb
        int cand;
        cand    = 0;
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(last_grant_q) + 1 + k) % NREQ;
            if (!w_found && bus.req_valid[cand[c_gw-1:0]]) begin
                w_found = 1'b1;
                w_win   = cand[c_gw-1:0];
            end
        end
    end

    always_comb begin : p_next
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        y_d          = y_q;
        flags_d      = flags_q;
        unique case (state_q)
            ST_IDLE: begin
                if (w_found) begin
                    grant_d = w_win;
                    a_d     = w_a[w_win];
                    b_d     = w_b[w_win];
                    op_d    = w_op[w_win];
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                y_d     = bus.alu_y;
                flags_d = {bus.alu_overflow, bus.alu_carry, bus.alu_zero, bus.alu_negative};
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready[grant_q]) begin
                    last_grant_d = grant_q;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_regs
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= c_last_init;
            grant_q      <= '0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            y_q          <= '0;
            flags_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            y_q          <= y_d;
            flags_q      <= flags_d;
        end
    end

    // The accept strobe is combinational, so it is also gated by reset.
    assign bus.req_ready = (state_q == ST_IDLE && w_found && rst_n) ? (c_one << w_win) : '0;
    assign bus.rsp_valid = (state_q == ST_RESP) ? (c_one << grant_q) : '0;
    assign bus.rsp_y     = y_q;
    assign bus.rsp_flags = flags_q;
    assign bus.alu_a     = a_q;
    assign bus.alu_b     = b_q;
    assign bus.alu_op    = op_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.grant_id  = grant_q;
endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Brief    : Self-checking bench for alu_arbiter with a transaction-level model.
// Revision : 1.0
// ============================================================================
module tb_alu_arbiter;
    localparam int W = 8;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_arbiter_if #(.WIDTH(W), .NREQ(N)) bus ();
    alu_arbiter #(.WIDTH(W), .NREQ(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference ALU: returns {overflow, carry, zero, negative, y}; carry is borrow on subtract.
    function automatic logic [11:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        logic [8:0] s;
        logic [7:0] y;
        logic       c;
        logic       v;
        s = '0; c = 1'b0; v = 1'b0;
        case (op)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; y = s[7:0]; c = s[8]; v = (a[7] == b[7]) && (y[7] != a[7]); end
            3'd1: begin s = {1'b0, a} - {1'b0, b}; y = s[7:0]; c = s[8]; v = (a[7] != b[7]) && (y[7] != a[7]); end
            3'd2: y = a & b;
            3'd3: y = a | b;
            3'd4: y = a ^ b;
            3'd5: y = a << 1;
            3'd6: y = a >> 1;
            default: y = b;
        endcase
        return {v, c, (y == 8'h00), y[7], y};
    endfunction

    logic [11:0] alu_r;
    assign alu_r            = alu_ref(bus.alu_a, bus.alu_b, bus.alu_op);
    assign bus.alu_y        = alu_r[7:0];
    assign bus.alu_negative = alu_r[8];
    assign bus.alu_zero     = alu_r[9];
    assign bus.alu_carry    = alu_r[10];
    assign bus.alu_overflow = alu_r[11];

    // Model: owner of the ALU (-1 when free) and cycles since its acceptance.
    int          m_owner, m_age, m_last, cyc;
    logic [7:0]  m_a, m_b;
    logic [2:0]  m_op;
    logic [11:0] m_res;
    int          dut_ids[$];
    int          dut_cyc[$];

    task automatic model_reset();
        m_owner = -1;
        m_age   = 0;
        m_last  = N - 1;
    endtask

    function automatic int m_winner();
        for (int k = 0; k < N; k++) begin
            if (bus.req_valid[(m_last + 1 + k) % N]) return (m_last + 1 + k) % N;
        end
        return -1;
    endfunction

    task automatic step();
        int w;
        @(negedge clk);
        w = (m_owner < 0) ? m_winner() : -1;
        for (int i = 0; i < N; i++) begin
            if (bus.req_ready[i]) begin
                dut_ids.push_back(i);
                dut_cyc.push_back(cyc);
            end
        end
        check_eq("req_ready", bus.req_ready, (w >= 0) ? (64'd1 << w) : 64'd0);
        check_eq("busy", bus.busy, (m_owner >= 0) ? 64'd1 : 64'd0);
        check_eq("rsp_valid", bus.rsp_valid, (m_owner >= 0 && m_age >= 2) ? (64'd1 << m_owner) : 64'd0);
        if (m_owner >= 0) begin
            check_eq("grant_id", bus.grant_id, m_owner);
            check_eq("alu_a", bus.alu_a, m_a);
            check_eq("alu_b", bus.alu_b, m_b);
            check_eq("alu_op", bus.alu_op, m_op);
            if (m_age >= 2) begin
                check_eq("rsp_y", bus.rsp_y, m_res[7:0]);
                check_eq("rsp_flags", bus.rsp_flags, m_res[11:8]);
            end
        end
        @(posedge clk);
        cyc++;
        if (m_owner < 0) begin
            if (w >= 0) begin
                m_owner = w;
                m_age   = 1;
                m_a     = bus.req_a[w*W +: W];
                m_b     = bus.req_b[w*W +: W];
                m_op    = bus.req_op[w*3 +: 3];
                m_res   = alu_ref(m_a, m_b, m_op);
            end
        end else if (m_age == 1) begin
            m_age = 2;
        end else if (bus.rsp_ready[m_owner]) begin
            m_last  = m_owner;
            m_owner = -1;
        end
        #1;
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_req_ready"}, bus.req_ready, 0);
        check_eq({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        check_eq({tag, "_rsp_y"}, bus.rsp_y, 0);
        check_eq({tag, "_rsp_flags"}, bus.rsp_flags, 0);
        check_eq({tag, "_alu_a"}, bus.alu_a, 0);
        check_eq({tag, "_alu_b"}, bus.alu_b, 0);
        check_eq({tag, "_alu_op"}, bus.alu_op, 0);
        check_eq({tag, "_grant_id"}, bus.grant_id, 0);
        check_eq({tag, "_busy"}, bus.busy, 0);
    endtask

    task automatic drain();
        bus.req_valid = '0;
        bus.rsp_ready = '1;
        for (int i = 0; i < 20 && bus.busy; i++) step();
        check_eq("drain_idle", bus.busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] y_hold;
        logic [3:0] f_hold;
        rst_n         = 1'b0;
        bus.req_valid = 4'hF;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.rsp_ready = '0;
        cyc           = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");

        // Round-robin from reset with everyone valid and responses always taken.
        rst_n = 1'b1;
        bus.rsp_ready = 4'hF;
        #1;
        check_eq("rst_first_ready", bus.req_ready, 4'b0001);
        dut_ids.delete();
        dut_cyc.delete();
        repeat (14) step();
        check_eq("rr_count", dut_ids.size(), 5);
        if (dut_ids.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                check_eq("rr_id", dut_ids[i], i % N);
                if (i > 0) check_eq("rr_gap", dut_cyc[i] - dut_cyc[i-1], 3);
            end
        end
        drain();

        // Add on requester 1, then hold the result under backpressure.
        bus.rsp_ready = '0;
        bus.req_valid = 4'b0010;
        bus.req_a     = 32'h0000_7F00;
        bus.req_b     = 32'h0000_0100;
        bus.req_op    = 12'h000;
        step();
        bus.req_valid = 4'hF;
        step();
        check_eq("add_rsp_valid", bus.rsp_valid, 4'b0010);
        check_eq("add_y", bus.rsp_y, 8'h80);
        check_eq("add_ovf", bus.rsp_flags[3], 1'b1);
        check_eq("add_carry", bus.rsp_flags[2], 1'b0);
        y_hold = bus.rsp_y;
        f_hold = bus.rsp_flags;
        repeat (5) begin
            step();
            check_eq("bp_y", bus.rsp_y, y_hold);
            check_eq("bp_flags", bus.rsp_flags, f_hold);
            check_eq("bp_req_ready", bus.req_ready, 0);
            check_eq("bp_rsp_valid", bus.rsp_valid, 4'b0010);
        end
        bus.rsp_ready = 4'b1101;
        step();
        check_eq("bp_other_ready", bus.rsp_valid, 4'b0010);
        bus.rsp_ready = 4'b0010;
        step();
        check_eq("bp_release_idle", bus.busy, 0);
        check_eq("bp_release_valid", bus.rsp_valid, 0);

        // Subtract on requester 2.
        bus.rsp_ready = '0;
        bus.req_valid = 4'b0100;
        bus.req_a     = 32'h0000_0000;
        bus.req_b     = 32'h0001_0000;
        bus.req_op    = 12'h040;
        step();
        bus.req_valid = '0;
        step();
        check_eq("sub_rsp_valid", bus.rsp_valid, 4'b0100);
        check_eq("sub_y", bus.rsp_y, 8'hFF);
        check_eq("sub_carry", bus.rsp_flags[2], 1'b1);
        check_eq("sub_ovf", bus.rsp_flags[3], 1'b0);
        bus.rsp_ready = 4'b0100;
        step();

        // Reset while requester 3 is in EXEC discards its operation.
        bus.rsp_ready = '0;
        bus.req_valid = 4'b1000;
        bus.req_a     = 32'h5A00_0000;
        bus.req_b     = 32'h3300_0000;
        bus.req_op    = 12'h000;
        step();
        check_eq("exec_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check_zero("rst_exec");
        rst_n = 1'b1;
        model_reset();
        bus.req_valid = 4'hF;
        bus.rsp_ready = 4'hF;
        step();
        check_eq("rst_exec_grant", bus.grant_id, 0);
        repeat (3) step();
        drain();

        // Randomised traffic: requests may appear and vanish before acceptance.
        repeat (400) begin
            bus.req_valid = 4'($urandom_range(0, 15));
            bus.req_a     = $urandom;
            bus.req_b     = $urandom;
            bus.req_op    = 12'($urandom_range(0, 4095));
            bus.rsp_ready = 4'($urandom_range(0, 15));
            step();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
